// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - MIPS-style decode stage with register file, scoreboard and one-entry output register
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid/in_ready     instruction handshake; in_ready is combinational
//   instr                 32-bit instruction word
//   out_valid/out_ready   decoded bundle handshake
//   out_op                opcode field
//   out_rs_val/out_rt_val source operand values (0 when the source is unused)
//   out_rd                destination register (0 = no write)
//   out_imm               sign-extended immediate
//   out_jaddr             jump target field
//   wb_valid/addr/data    write-back port; clears the pending bit of wb_addr
//   flush                 squash the bundle held in the output register
module decode_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_op,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [AW-1:0]     out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [25:0]       out_jaddr,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;

    logic [5:0]        op;
    logic [AW-1:0]     rs_a;
    logic [AW-1:0]     rt_a;
    logic [AW-1:0]     rd_a;
    logic [AW-1:0]     dst;
    logic              use_rs;
    logic              use_rt;
    logic              has_dst;

    logic              wb_hit_rs;
    logic              wb_hit_rt;
    logic              wb_hit_dst;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              hazard;
    logic              accept;

    assign op   = instr[31:26];
    assign rs_a = instr[21 +: AW];
    assign rt_a = instr[16 +: AW];
    assign rd_a = instr[11 +: AW];
    assign imm  = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        has_dst = 1'b0;
        dst     = '0;
        case (op)
            OP_RTYPE: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                has_dst = 1'b1;
                dst     = rd_a;
            end
            OP_ADDI, OP_LW: begin
                use_rs  = 1'b1;
                has_dst = 1'b1;
                dst     = rt_a;
            end
            OP_BEQ, OP_SW: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: begin
                use_rs  = 1'b0;
                use_rt  = 1'b0;
                has_dst = 1'b0;
                dst     = '0;
            end
        endcase
    end

    // A write-back landing this cycle both supplies the operand (bypass)
    // and retires the pending bit, so it never causes a stall.
    assign wb_hit_rs  = wb_valid && (wb_addr == rs_a);
    assign wb_hit_rt  = wb_valid && (wb_addr == rt_a);
    assign wb_hit_dst = wb_valid && (wb_addr == dst);

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (use_rs && (rs_a != '0)) begin
            rs_val = wb_hit_rs ? wb_data : regs[rs_a];
        end
        if (use_rt && (rt_a != '0)) begin
            rt_val = wb_hit_rt ? wb_data : regs[rt_a];
        end
    end

    // pending[0] is held at 0, so r0 can never stall.
    assign hazard = (use_rs  && pending[rs_a] && !wb_hit_rs)
                 || (use_rt  && pending[rt_a] && !wb_hit_rt)
                 || (has_dst && pending[dst]  && !wb_hit_dst);

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Ordering gives the accept set priority over any clear on the same bit.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (flush && out_valid) begin
            pending_nxt[out_rd] = 1'b0;
        end
        if (accept && has_dst) begin
            pending_nxt[dst] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_rs_val <= '0;
            out_rt_val <= '0;
            out_rd     <= '0;
            out_imm    <= '0;
            out_jaddr  <= '0;
        end else begin
            pending <= pending_nxt;
            if (accept) begin
                out_valid  <= 1'b1;
                out_op     <= op;
                out_rs_val <= rs_val;
                out_rt_val <= rt_val;
                out_rd     <= dst;
                out_imm    <= imm;
                out_jaddr  <= instr[25:0];
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
